// File: rtl/game_pkg.sv
// Shared game definitions: round state encoding and common field widths.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
// Used by the round sequencer, mole generator and display blocks.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        PLAY  = 2'd2,
        OVER  = 2'd3
    } game_state_e;

    localparam int SECS_W  = 7;
    localparam int SPAWN_W = 11;
    localparam int CD_W    = 2;

endpackage

// File: rtl/tick_prescaler.sv
// Shared timebase: single-cycle ms and second enable ticks from clk.
// Latency: ms_tick one cycle after the divider reaches MS_DIV-1; period MS_DIV clocks.
// Backpressure: en=0 holds all counts and suppresses ticks; clr restarts phase at zero.
// Ports: clk, rst_n (async active-low), en (count enable), clr (phase reset),
//        ms_tick / sec_tick (registered one-cycle pulses; sec_tick coincides with
//        the ms_tick that wraps the ms counter).
module tick_prescaler #(
    parameter int MS_DIV     = 100_000,
    parameter int MS_PER_SEC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic ms_tick,
    output logic sec_tick
);

    localparam int DIV_W = $clog2(MS_DIV);
    localparam int MSC_W = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MS_DIV - 1);
    localparam logic [MSC_W-1:0] MSC_LAST = MSC_W'(MS_PER_SEC - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [MSC_W-1:0] ms_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            ms_cnt   <= '0;
            ms_tick  <= 1'b0;
            sec_tick <= 1'b0;
        end else if (clr) begin
            div_cnt  <= '0;
            ms_cnt   <= '0;
            ms_tick  <= 1'b0;
            sec_tick <= 1'b0;
        end else if (!en) begin
            // Hold phase; no ticks while frozen.
            ms_tick  <= 1'b0;
            sec_tick <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            ms_tick <= 1'b1;
            if (ms_cnt == MSC_LAST) begin
                ms_cnt   <= '0;
                sec_tick <= 1'b1;
            end else begin
                ms_cnt   <= ms_cnt + 1'b1;
                sec_tick <= 1'b0;
            end
        end else begin
            div_cnt  <= div_cnt + 1'b1;
            ms_tick  <= 1'b0;
            sec_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/game_tick_ctrl.sv
// Whack-a-mole round sequencer: IDLE -> READY countdown -> PLAY -> OVER, plus spawn pacing.
// Latency: state/counter updates one cycle after the triggering tick or pulse; spawn one cycle after its ms_tick.
// Backpressure: pause (READY/PLAY) freezes all timing and suppresses ticks/spawn; abort wins over everything.
// Ports: clk, rst_n (async active-low), start/abort (pulses), pause (level);
//        state, ms_tick, sec_tick, spawn, countdown, secs_left, spawn_ms, game_over (all registered).
module game_tick_ctrl
    import game_pkg::*;
#(
    parameter int MS_DIV         = 100_000,
    parameter int MS_PER_SEC     = 1000,
    parameter int COUNTDOWN_SECS = 3,
    parameter int ROUND_SECS     = 60,
    parameter int SPAWN_MS_INIT  = 1000,
    parameter int SPAWN_MS_MIN   = 300,
    parameter int SPAWN_MS_STEP  = 100,
    parameter int SPEEDUP_SECS   = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               pause,
    input  logic               abort,
    output logic [1:0]         state,
    output logic               ms_tick,
    output logic               sec_tick,
    output logic               spawn,
    output logic [CD_W-1:0]    countdown,
    output logic [SECS_W-1:0]  secs_left,
    output logic [SPAWN_W-1:0] spawn_ms,
    output logic               game_over
);

    localparam int SPD_W = (SPEEDUP_SECS > 1) ? $clog2(SPEEDUP_SECS) : 1;
    localparam logic [SPD_W-1:0]   SPD_LAST   = SPD_W'(SPEEDUP_SECS - 1);
    localparam logic [SPAWN_W-1:0] SPAWN_INIT = SPAWN_W'(SPAWN_MS_INIT);

    game_state_e        st;
    logic [SPAWN_W-1:0] spawn_cnt;
    logic [SPD_W-1:0]   speed_cnt;   // elapsed PLAY seconds modulo SPEEDUP_SECS
    logic [SPAWN_W-1:0] spawn_ms_dec;
    logic               run;
    logic               start_ok;
    logic               ready_done;
    logic               play_done;
    logic               clr;

    assign state = st;

    assign run        = ((st == READY) || (st == PLAY)) && !pause;
    assign start_ok   = start && ((st == IDLE) || (st == OVER));
    assign ready_done = (st == READY) && sec_tick && (countdown == CD_W'(1));
    assign play_done  = (st == PLAY) && sec_tick && (secs_left == SECS_W'(1));
    // Any state entry restarts the timebase phase in the same edge as the transition.
    assign clr        = abort || start_ok || ready_done || play_done;

    // Saturating decrement: never below the floor, never wraps.
    always_comb begin
        spawn_ms_dec = SPAWN_W'(SPAWN_MS_MIN);
        if (spawn_ms > SPAWN_W'(SPAWN_MS_MIN + SPAWN_MS_STEP))
            spawn_ms_dec = spawn_ms - SPAWN_W'(SPAWN_MS_STEP);
    end

    tick_prescaler #(
        .MS_DIV     (MS_DIV),
        .MS_PER_SEC (MS_PER_SEC)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (run),
        .clr      (clr),
        .ms_tick  (ms_tick),
        .sec_tick (sec_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            countdown <= '0;
            secs_left <= '0;
            spawn_ms  <= SPAWN_INIT;
            spawn_cnt <= '0;
            speed_cnt <= '0;
            spawn     <= 1'b0;
            game_over <= 1'b0;
        end else begin
            spawn <= 1'b0;
            if (abort) begin
                st        <= IDLE;
                countdown <= '0;
                secs_left <= '0;
                spawn_ms  <= SPAWN_INIT;
                spawn_cnt <= '0;
                speed_cnt <= '0;
                game_over <= 1'b0;
            end else begin
                case (st)
                    IDLE, OVER: begin
                        if (start) begin
                            st        <= READY;
                            countdown <= CD_W'(COUNTDOWN_SECS);
                            game_over <= 1'b0;
                        end
                    end
                    READY: begin
                        if (sec_tick) begin
                            if (countdown == CD_W'(1)) begin
                                st        <= PLAY;
                                countdown <= '0;
                                secs_left <= SECS_W'(ROUND_SECS);
                                spawn_ms  <= SPAWN_INIT;
                                spawn_cnt <= '0;
                                speed_cnt <= '0;
                            end else begin
                                countdown <= countdown - 1'b1;
                            end
                        end
                    end
                    PLAY: begin
                        if (ms_tick) begin
                            // >= so a freshly shrunk interval below the count fires at once.
                            if (spawn_cnt >= spawn_ms - 1'b1) begin
                                spawn_cnt <= '0;
                                spawn     <= !play_done;
                            end else begin
                                spawn_cnt <= spawn_cnt + 1'b1;
                            end
                        end
                        if (sec_tick) begin
                            if (secs_left == SECS_W'(1)) begin
                                st        <= OVER;
                                secs_left <= '0;
                                game_over <= 1'b1;
                            end else begin
                                secs_left <= secs_left - 1'b1;
                                if (speed_cnt == SPD_LAST) begin
                                    speed_cnt <= '0;
                                    spawn_ms  <= spawn_ms_dec;
                                end else begin
                                    speed_cnt <= speed_cnt + 1'b1;
                                end
                            end
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_tick_ctrl.sv
// Directed bench for game_tick_ctrl with small timing parameters.
// Latency: n/a.
// Backpressure: n/a.
module tb_game_tick_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        pause;
    logic        abort;
    logic [1:0]  state;
    logic        ms_tick;
    logic        sec_tick;
    logic        spawn;
    logic [1:0]  countdown;
    logic [6:0]  secs_left;
    logic [10:0] spawn_ms;
    logic        game_over;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    game_tick_ctrl #(
        .MS_DIV         (4),
        .MS_PER_SEC     (10),
        .COUNTDOWN_SECS (3),
        .ROUND_SECS     (5),
        .SPAWN_MS_INIT  (4),
        .SPAWN_MS_MIN   (2),
        .SPAWN_MS_STEP  (1),
        .SPEEDUP_SECS   (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pause     (pause),
        .abort     (abort),
        .state     (state),
        .ms_tick   (ms_tick),
        .sec_tick  (sec_tick),
        .spawn     (spawn),
        .countdown (countdown),
        .secs_left (secs_left),
        .spawn_ms  (spawn_ms),
        .game_over (game_over)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return sec_tick;
            1:       return spawn;
            default: return ms_tick;
        endcase
    endfunction

    // Step until the selected pulse is seen; t is the cycle stamp of that pulse.
    task automatic wait_evt(input int which, output int t);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!sel(which) && n < 600);
        if (!sel(which)) check_val("wait_timeout", which, -1);
        t = cyc;
    endtask

    int t, tp, te, tpl, bad;

    initial begin
        rst_n = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // 1. Reset mid-stream
        start = 1'b1; step(); start = 1'b0;
        repeat (20) step();
        rst_n = 1'b0; #1;
        check_val("rst_state", state, 0);
        check_val("rst_countdown", countdown, 0);
        check_val("rst_secs_left", secs_left, 0);
        check_val("rst_spawn_ms", spawn_ms, 4);
        check_val("rst_pulses", ms_tick + sec_tick + spawn + game_over, 0);
        step(); rst_n = 1'b1; step();
        check_val("idle_after_rst", state, 0);

        start = 1'b1; step(); start = 1'b0;
        check_val("start_state", state, 1);
        check_val("start_countdown", countdown, 3);
        te = cyc;

        // 2. READY countdown
        wait_evt(0, t);
        check_val("cd_sec1_dt", t - te, 40);
        check_val("cd_at_tick", countdown, 3);
        step();
        check_val("cd_after1", countdown, 2);
        tp = t;
        wait_evt(0, t);
        check_val("cd_sec2_dt", t - tp, 40);
        step();
        check_val("cd_after2", countdown, 1);
        tp = t;
        wait_evt(0, t);
        check_val("cd_sec3_dt", t - tp, 40);
        check_val("ready_at_tick3", state, 1);
        step();
        check_val("play_state", state, 2);
        check_val("play_secs_left", secs_left, 5);
        check_val("play_countdown", countdown, 0);
        tpl = cyc;

        // 3. Spawn pacing and speed-up
        wait_evt(1, t);
        check_val("spawn_first", t - tpl, 17);
        tp = t;
        wait_evt(1, t);
        check_val("spawn_dt16", t - tp, 16);
        wait_evt(0, t);
        check_val("play_sec1", t - tpl, 40);
        step();
        check_val("secs_left_4", secs_left, 4);
        wait_evt(0, t);
        check_val("play_sec2", t - tpl, 80);
        step();
        check_val("secs_left_3", secs_left, 3);
        check_val("spawn_ms_3", spawn_ms, 3);
        check_val("spawn_old_interval", spawn, 1);
        wait_evt(1, t);
        check_val("spawn_12a", t - tpl, 93);
        wait_evt(1, t);
        check_val("spawn_12b", t - tpl, 105);

        // 4. Pause for 100 clocks
        pause = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            bad += ms_tick + sec_tick + spawn;
        end
        check_val("pause_quiet", bad, 0);
        check_val("pause_secs_left", secs_left, 3);
        check_val("pause_spawn_ms", spawn_ms, 3);
        pause = 1'b0;
        wait_evt(0, t);
        check_val("play_sec3_shift", t - tpl, 220);
        step();
        check_val("secs_left_2", secs_left, 2);
        wait_evt(0, t);
        check_val("play_sec4_shift", t - tpl, 260);
        step();
        check_val("spawn_ms_2", spawn_ms, 2);
        wait_evt(1, t);
        check_val("spawn_shrink_ge", t - tpl, 265);
        tp = t;
        wait_evt(1, t);
        check_val("spawn_dt8a", t - tp, 8);
        tp = t;
        wait_evt(1, t);
        check_val("spawn_dt8b", t - tp, 8);
        check_val("spawn_ms_floor", spawn_ms, 2);

        // 5. Round end
        wait_evt(0, t);
        check_val("play_sec5", t - tpl, 300);
        step();
        check_val("over_state", state, 3);
        check_val("over_game_over", game_over, 1);
        check_val("over_secs_left", secs_left, 0);
        check_val("over_no_spawn", spawn, 0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            bad += ms_tick + sec_tick + spawn;
        end
        check_val("over_quiet", bad, 0);
        start = 1'b1; step(); start = 1'b0;
        check_val("restart_state", state, 1);
        check_val("restart_game_over", game_over, 0);
        check_val("restart_countdown", countdown, 3);
        te = cyc;

        // 6. start ignored in READY, abort wins over start, reset mid-PLAY
        start = 1'b1; step(); start = 1'b0;
        check_val("ready_start_ignored", state, 1);
        wait_evt(0, t);
        check_val("ready_phase_kept", t - te, 40);
        wait_evt(0, t);
        wait_evt(0, t);
        step();
        check_val("play_again", state, 2);
        abort = 1'b1; start = 1'b1; step(); abort = 1'b0; start = 1'b0;
        check_val("abort_state", state, 0);
        check_val("abort_secs_left", secs_left, 0);
        step();
        check_val("abort_stays_idle", state, 0);

        start = 1'b1; step(); start = 1'b0;
        repeat (3) wait_evt(0, t);
        step();
        check_val("play_third", state, 2);
        wait_evt(0, t);
        wait_evt(0, t);
        step();
        check_val("pre_rst_spawn_ms", spawn_ms, 3);
        rst_n = 1'b0; #1;
        check_val("midplay_rst_state", state, 0);
        check_val("midplay_rst_spawn_ms", spawn_ms, 4);
        check_val("midplay_rst_secs_left", secs_left, 0);
        step(); rst_n = 1'b1; step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_tick_ctrl.md
Name: game_tick_ctrl

Overview:
- Round sequencer and timebase for the whack-a-mole game.
- Owns one shared prescaler that produces single-cycle enable ticks: ms, second and mole-spawn. No derived clocks are generated.
- Runs the round flow IDLE → READY countdown → PLAY → OVER.
- Shortens the spawn interval as the round progresses. Drives the mole generator, score logic and display.

Parameters:
- MS_DIV, 100_000: clk cycles per ms tick (100 MHz). Range 2..2^20.
- MS_PER_SEC, 1000: ms ticks per second tick. Overridden small in simulation.
- COUNTDOWN_SECS, 3: READY countdown length. Range 1..3.
- ROUND_SECS, 60: PLAY length. Range 1..127.
- SPAWN_MS_INIT, 1000: initial spawn interval in ms ticks. Range ≤2047.
- SPAWN_MS_MIN, 300: spawn interval floor. Range ≥1.
- SPAWN_MS_STEP, 100: interval decrement per speed-up.
- SPEEDUP_SECS, 10: elapsed PLAY seconds between speed-ups.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: one-cycle pulse; begins a round.
- pause, in, 1: level; freezes timing in READY/PLAY.
- abort, in, 1: one-cycle pulse; return to IDLE.
- state, out, 2: 0 IDLE, 1 READY, 2 PLAY, 3 OVER.
- ms_tick, out, 1: one-cycle pulse per ms.
- sec_tick, out, 1: one-cycle pulse per second.
- spawn, out, 1: one-cycle pulse; request a new mole.
- countdown, out, 2: READY seconds remaining.
- secs_left, out, 7: PLAY seconds remaining.
- spawn_ms, out, 11: current spawn interval.
- game_over, out, 1: high while in OVER.

Behaviour:
- Single clock domain. rst_n is asynchronous assert and is released synchronously upstream.
- Reset values: state=IDLE; all ticks, spawn, countdown, secs_left and game_over = 0; spawn_ms=SPAWN_MS_INIT; all internal counters 0.
- All outputs are registered. Pulses are exactly one cycle wide.
- Prescaler:
  - Counts 0..MS_DIV-1 only when state is READY/PLAY and pause=0.
  - ms_tick is asserted the cycle after the count reaches MS_DIV-1, so the ms_tick period is exactly MS_DIV clocks.
  - ms counter 0..MS_PER_SEC-1 advances on each ms_tick. sec_tick coincides with the ms_tick that wraps it.
  - Prescaler and ms counter clear on every state entry, so the first sec_tick comes MS_DIV*MS_PER_SEC clocks after entry.
- pause=1: all counters hold; ms_tick, sec_tick and spawn are suppressed. Phase resumes exactly where it stopped. pause has no effect in IDLE/OVER.
- Transitions, evaluated in priority order:
  - abort, any state → IDLE next cycle. Takes priority over start and sec_tick; counters cleared.
  - IDLE + start → READY; countdown=COUNTDOWN_SECS.
  - READY: each sec_tick decrements countdown. The sec_tick seen with countdown==1 → PLAY, with secs_left=ROUND_SECS, spawn_ms=SPAWN_MS_INIT, spawn counter=0, elapsed=0; countdown becomes 0.
  - PLAY: each sec_tick decrements secs_left and increments elapsed. The sec_tick seen with secs_left==1 → OVER: secs_left=0, game_over=1.
  - OVER + start → READY, identical to the IDLE start.
  - start in READY/PLAY is ignored.
- Spawn, PLAY only:
  - Spawn counter increments on each ms_tick.
  - When an ms_tick arrives with counter ≥ spawn_ms-1: spawn=1 and the counter returns to 0.
  - The ≥ comparison covers an interval shrinking below the current count.
  - A spawn coinciding with the final sec_tick is suppressed.
- Speed-up:
  - On a PLAY sec_tick where the new elapsed value is a nonzero multiple of SPEEDUP_SECS: spawn_ms = max(spawn_ms - SPAWN_MS_STEP, SPAWN_MS_MIN).
  - Saturating arithmetic, no underflow wrap. The new value applies from the next ms_tick.
- game_over deasserts on the cycle state leaves OVER.
- Reset mid-round: immediate return to reset values.

Decomposition:
- Package game_pkg:
  - state encoding constants IDLE/READY/PLAY/OVER (2-bit);
  - width constants SECS_W=7, SPAWN_W=11, CD_W=2;
  - shared by the mole generator and display blocks.
- Sub-module tick_prescaler (MS_DIV, MS_PER_SEC):
  - inputs: clk, rst_n, en, clr;
  - outputs: ms_tick, sec_tick.
  - Replaces the free-running toggle divider for all game timing.

Test Plan:
Bench parameters for all scenarios: MS_DIV=4, MS_PER_SEC=10, COUNTDOWN_SECS=3, ROUND_SECS=5, SPAWN_MS_INIT=4, SPAWN_MS_MIN=2, SPAWN_MS_STEP=1, SPEEDUP_SECS=2.
1. Reset asserted mid-stream, then released → state=0, all pulses 0, spawn_ms=4, secs_left=0; start pulse → state=1, countdown=3 next cycle.
2. After start, no pause → sec_tick every 40 clocks; countdown 3→2→1; third sec_tick → state=2, secs_left=5.
3. PLAY → spawn every 16 clocks; after the 2nd PLAY sec_tick, spawn_ms=3 (12 clocks); after the 4th, spawn_ms=2 (8 clocks); never below 2.
4. pause held 100 clocks in PLAY → no ms_tick/sec_tick/spawn; secs_left and spawn_ms frozen; next sec_tick arrives at the original phase offset + 100.
5. 5th PLAY sec_tick → state=3, game_over=1, secs_left=0, no spawn on that cycle; start → state=1, game_over=0.
6. abort and start in the same cycle during PLAY → state=0; start in READY → ignored; rst_n low mid-PLAY → immediate reset values.
